mac_accumulator_32: RTL
=======================

// Module: mac_accumulator_32
// PURPOSE
// - Downstream consumer of the 16x16 Wallace multiplier: sums a programmed number of 32-bit unsigned products into a wide accumulator.
// - Handshakes: valid/ready on the product input, valid/ready on the result output.
// - Forms the accumulate half of the dot-product datapath (multiplier -> this block -> result sink).
// PARAMETERS
// - PROD_W   32  product input width (matches 16x16 multiplier output)
// - ACC_W    40  accumulator/result width; must be >= PROD_W
// - CNT_W     8  term-count width; max 2^CNT_W-1 terms per job
// PORTS
// - clk        in   1      single clock, rising edge
// - rst_n      in   1      asynchronous active-low reset
// - start      in   1      1-cycle job start pulse; sampled only in IDLE
// - term_cnt   in   CNT_W  number of products in the job; sampled with start
// - abort      in   1      synchronous abort; returns to IDLE from any state
// - prod_valid in   1      product input valid
// - prod       in   PROD_W unsigned product from multiplier
// - prod_ready out  1      block accepts product this cycle
// - res_valid  out  1      result available
// - res_ready  in   1      sink accepts result
// - result     out  ACC_W  accumulated sum
// - ovf        out  1      sticky: carry out of ACC_W occurred during job
// - busy       out  1      high in ACCUM or DONE
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE; acc=0, remaining=0, ovf=0; prod_ready=0, res_valid=0, busy=0; result=0.
// - FSM states IDLE, ACCUM, DONE; all outputs registered or decoded from the state register only.
// - IDLE: prod_ready=0. start=1 & term_cnt!=0 -> acc<=0, ovf<=0, remaining<=term_cnt, next ACCUM.
//   start=1 & term_cnt==0 -> acc<=0, ovf<=0, next DONE (empty job, result 0).
// - ACCUM: prod_ready=1. Transfer = prod_valid & prod_ready.
//   On transfer: acc<=acc+zero-extended prod (mod 2^ACC_W); ovf<=ovf|carry; remaining<=remaining-1.
//   Transfer with remaining==1 -> next DONE. No transfer -> hold all state (stalls unbounded).
// - DONE: res_valid=1, result=acc, ovf valid. res_valid & res_ready -> next IDLE; otherwise hold result stable.
// - Latency: res_valid rises the cycle after the final product transfer; start-to-prod_ready is 1 cycle.
// - Back-to-back: start may be asserted in the cycle after the DONE->IDLE transition (no dead cycle beyond IDLE).
// - start while not IDLE: ignored (no state change, term_cnt not sampled).
// - abort (priority over every other input, incl. start and handshakes): next IDLE, acc<=0, ovf<=0, remaining<=0; an in-flight transfer in the same cycle is discarded.
// - rst_n low mid-job: immediate return to reset values; no partial result emitted.
// - result drives acc in all states; it is meaningful only while res_valid=1.
// CONFIGURATION
// - SATURATE_ACC_EN defined: addition saturates; if carry out of ACC_W, acc<=all ones and stays clamped for the rest of the job; ovf still set.
// - SATURATE_ACC_EN undefined: addition wraps modulo 2^ACC_W; ovf flags the wrap.
// TESTING
// - Reset: assert rst_n=0 mid-ACCUM -> all outputs 0, state IDLE next edge.
// - Basic job: start, term_cnt=3; products 0xFFFE0001, 0x00000010, 0x00000005 with prod_valid always 1
//   -> res_valid 1 cycle after 3rd transfer, result=0x00FFFE0016, ovf=0.
// - Stalls/backpressure: same job with prod_valid gaps of 0-4 cycles and res_ready low 5 cycles
//   -> identical result; result stable while res_valid & !res_ready.
// - Empty job: start, term_cnt=0 -> DONE next cycle, result=0, ovf=0, prod_ready never high.
// - Overflow: ACC_W=33, 3 x 0xFFFFFFFF -> wrap build: result=0x0FFFFFFFD, ovf=1;
//   SATURATE_ACC_EN: result=0x1FFFFFFFF, ovf=1.
// - Abort/ignored start: start term_cnt=4, 2 transfers, abort with prod_valid=1 -> IDLE, no res_valid;
//   start pulse during ACCUM leaves remaining unchanged.

Source files
------------

// File: rtl/mac_accumulator_32.sv
// mac_accumulator_32
// Sums a programmed number of unsigned products from the 16x16 multiplier
// into a wide accumulator. Products arrive on a valid/ready handshake and the
// sum leaves on a second valid/ready handshake.
// Optional feature macro: SATURATE_ACC_EN. When it is defined, the accumulator
// clamps to all ones on carry-out instead of wrapping. In both builds ovf is
// the sticky carry-out flag for the job.
module mac_accumulator_32 #(
  parameter int PROD_W = 32,
  parameter int ACC_W  = 40,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  term_cnt,
  input  logic              abort,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] prod,
  output logic              prod_ready,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  result,
  output logic              ovf,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [ACC_W-1:0]   acc, acc_nxt;
  logic [CNT_W-1:0]   remaining, remaining_nxt;
  logic               ovf_q, ovf_nxt;
  logic [ACC_W:0]     sum;
  logic [ACC_W-1:0]   acc_add;
  logic               xfer;

  // A product is taken only while accumulating; prod_ready comes from the state register.
  assign xfer = prod_valid && (state == ACCUM);

  // One extra bit catches the carry out of the accumulator width.
  assign sum = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};

`ifdef SATURATE_ACC_EN
  // Saturating build: clamp to all ones on carry. Once clamped, every later non-zero add carries again, so the value stays pinned.
  always_comb begin
    acc_add = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
  end
`else
  // Wrapping build: keep the low ACC_W bits (modulo 2^ACC_W).
  always_comb begin
    acc_add = sum[ACC_W-1:0];
  end
`endif

  // Next-state and datapath updates. Abort overrides every other input.
  always_comb begin
    state_nxt     = state;
    acc_nxt       = acc;
    remaining_nxt = remaining;
    ovf_nxt       = ovf_q;
    if (abort) begin
      state_nxt     = IDLE;
      acc_nxt       = '0;
      remaining_nxt = '0;
      ovf_nxt       = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc_nxt       = '0;
            ovf_nxt       = 1'b0;
            remaining_nxt = term_cnt;
            state_nxt     = (term_cnt == '0) ? DONE : ACCUM;
          end
        end
        ACCUM: begin
          if (xfer) begin
            acc_nxt       = acc_add;
            ovf_nxt       = ovf_q | sum[ACC_W];
            remaining_nxt = remaining - 1'b1;
            if (remaining == CNT_W'(1)) begin
              state_nxt = DONE;
            end
          end
        end
        DONE: begin
          if (res_ready) begin
            state_nxt = IDLE;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers. Reset is asynchronous and active low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      remaining <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      remaining <= remaining_nxt;
      ovf_q     <= ovf_nxt;
    end
  end

  // All outputs are decoded from registers only. result shows acc in every state.
  assign prod_ready = (state == ACCUM);
  assign res_valid  = (state == DONE);
  assign busy       = (state != IDLE);
  assign result     = acc;
  assign ovf        = ovf_q;

endmodule
